// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: shared types and widths
// for the SRAM access sequencer
package mem_seq_pkg;

  localparam int WAIT_W = 3;
  localparam int BEAT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD
  } state_e;

endpackage

// File: rtl/mem_seq_wait.sv
// mem_seq_wait: loadable down-counter
// with zero flag, times the strobe phase
module mem_seq_wait #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  // load wins over decrement; stop at zero
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_sequencer.sv
// mem_sequencer: byte-wide async SRAM sequencer
// SETUP/STROBE/HOLD beats, bursts, wait states
module mem_sequencer
  import mem_seq_pkg::*;
#(
  parameter int WAIT_STATES = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] ADDR,
  input  logic        REQ,
  input  logic        WE,
  input  logic [3:0]  BURST_LEN,
  input  logic [7:0]  DATA_in,
  output logic [7:0]  DATA_out,
  output logic        DATA_VALID,
  output logic        DONE,
  output logic        BUSY,
  output logic        ADDR_INC,
  output logic [15:0] MEM_ADDR,
  output logic [7:0]  MEM_DATA_out,
  output logic        MEM_DATA_oe,
  input  logic [7:0]  MEM_DATA_in,
  output logic        MEM_CE_bar,
  output logic        MEM_OE_bar,
  output logic        MEM_WE_bar
);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [BEAT_W-1:0] beats_q, beats_d;
  logic [15:0]       addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d;
  logic [7:0]        rdata_q, rdata_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              inc_q, inc_d;
  logic              oe_q, oe_d;
  logic              ce_n_q, ce_n_d;
  logic              oe_n_q, oe_n_d;
  logic              we_n_q, we_n_d;

  logic wait_load;
  logic wait_dec;
  logic wait_zero;
  logic last_strobe;
  logic last_beat;

  assign wait_load = (state_q == S_SETUP);
  assign wait_dec  = (state_q == S_STROBE);

  mem_seq_wait #(
    .W(WAIT_W)
  ) u_wait (
    .clk     (CLK),
    .rst     (RST),
    .load    (wait_load),
    .load_val(WAIT_W'(WAIT_STATES)),
    .dec     (wait_dec),
    .zero    (wait_zero)
  );

  // next state, datapath, and strobes
  // derived from the next state so
  // every output comes straight off a flop
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    beats_d = beats_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;

    last_strobe = (state_q == S_STROBE)
                  && wait_zero;
    last_beat   = (beats_q == '0);

    unique case (state_q)
      S_IDLE: begin
        if (REQ) begin
          state_d = S_SETUP;
          we_d    = WE;
          beats_d = BURST_LEN;
          addr_d  = ADDR;
          wdata_d = DATA_in;
        end
      end
      S_SETUP: begin
        state_d = S_STROBE;
      end
      S_STROBE: begin
        if (wait_zero) begin
          state_d = S_HOLD;
          if (!we_q) begin
            rdata_d = MEM_DATA_in;
          end
        end
      end
      S_HOLD: begin
        if (last_beat) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_SETUP;
          beats_d = beats_q - BEAT_W'(1);
          addr_d  = addr_q + 16'd1;
          wdata_d = DATA_in;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d  = (state_d != S_IDLE);
    ce_n_d  = !busy_d;
    oe_n_d  = !(busy_d && !we_d);
    oe_d    = busy_d && we_d;
    we_n_d  = !((state_d == S_STROBE) && we_d);
    valid_d = last_strobe;
    done_d  = last_strobe && last_beat;
    inc_d   = last_strobe && !last_beat;
  end

  // state and output registers, sync reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      beats_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      inc_q   <= 1'b0;
      oe_q    <= 1'b0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      beats_q <= beats_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      inc_q   <= inc_d;
      oe_q    <= oe_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
    end
  end

  assign DATA_out     = rdata_q;
  assign DATA_VALID   = valid_q;
  assign DONE         = done_q;
  assign BUSY         = busy_q;
  assign ADDR_INC     = inc_q;
  assign MEM_ADDR     = addr_q;
  assign MEM_DATA_out = wdata_q;
  assign MEM_DATA_oe  = oe_q;
  assign MEM_CE_bar   = ce_n_q;
  assign MEM_OE_bar   = oe_n_q;
  assign MEM_WE_bar   = we_n_q;

endmodule
